// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths and writeback requester indices.
package cpu_pkg;

    localparam int DW       = 16;
    localparam int AW       = 3;
    localparam int NREQ_WB  = 4;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_MUL  = 2;
    localparam int REQ_DBG  = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority picker: first set request at or after ptr, wrapping at N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          gnt_v_o
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_v_o   = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            // Modulo-N add so non-power-of-two N wraps correctly.
            sum = {1'b0, ptr_i} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
            idx = sum[IW-1:0];
            if (!gnt_v_o && req_i[idx]) begin
                gnt_v_o     = 1'b1;
                gnt_o[idx]  = 1'b1;
                gnt_idx_o   = idx;
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port among writeback
// sources, with one registered output stage that the core can stall.
module regfile_wr_arbiter
    import cpu_pkg::*;
#(
    parameter int NREQ    = cpu_pkg::NREQ_WB,
    parameter int DW      = cpu_pkg::DW,
    parameter int AW      = cpu_pkg::AW,
    parameter int ZERO_RO = 1,
    parameter int IW      = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic               rf_stall,
    output logic               rf_we,
    output logic [AW-1:0]      rf_waddr,
    output logic [DW-1:0]      rf_wdata,
    output logic [IW-1:0]      grant_id,
    output logic               idle
);

    logic          out_v_q, out_v_d;
    logic [AW-1:0] out_addr_q, out_addr_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [IW-1:0] out_id_q, out_id_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;

    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_v;
    logic            accept, xfer, retire;

    rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
        .req_i     (req_valid),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_v_o   (gnt_v)
    );

    // The stage can load whenever it is empty or draining this cycle.
    assign accept    = ~out_v_q | ~rf_stall;
    assign retire    = out_v_q & ~rf_stall;
    assign xfer      = accept & gnt_v;
    assign req_ready = accept ? gnt : '0;

    always_comb begin
        out_v_d    = out_v_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        out_id_d   = out_id_q;
        rr_ptr_d   = rr_ptr_q;
        if (xfer) begin
            out_v_d    = 1'b1;
            out_addr_d = req_addr[int'(gnt_idx)*AW +: AW];
            out_data_d = req_data[int'(gnt_idx)*DW +: DW];
            out_id_d   = gnt_idx;
            rr_ptr_d   = (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
        end else if (retire) begin
            out_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_v_q    <= 1'b0;
            out_addr_q <= '0;
            out_data_q <= '0;
            out_id_q   <= '0;
            rr_ptr_q   <= '0;
        end else begin
            out_v_q    <= out_v_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            out_id_q   <= out_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    // Register 0 is hardwired: its writes retire normally but never strobe the file.
    assign rf_we    = out_v_q & ~rf_stall & ~((ZERO_RO != 0) && (out_addr_q == '0));
    assign rf_waddr = out_addr_q;
    assign rf_wdata = out_data_q;
    assign grant_id = out_id_q;
    assign idle     = ~out_v_q & ~|req_valid;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scenario bench for regfile_wr_arbiter: scoreboard of expected register writes.
module tb_regfile_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 16;
    localparam int AW   = 3;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    id;
    } wr_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic               rf_stall;
    logic               rf_we;
    logic [AW-1:0]      rf_waddr;
    logic [DW-1:0]      rf_wdata;
    logic [1:0]         grant_id;
    logic               idle;

    int  errors = 0;
    int  checks = 0;
    wr_t sb[$];

    regfile_wr_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .ZERO_RO(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rf_stall  (rf_stall),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .grant_id  (grant_id),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    // Every write strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rf_we === 1'b1) begin
            wr_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%h id=%0d, required no write",
                         rf_waddr, rf_wdata, grant_id);
            end else begin
                e = sb.pop_front();
                if (rf_waddr !== e.addr || rf_wdata !== e.data || grant_id !== e.id) begin
                    errors++;
                    $display("FAIL sb_write: got addr=%0d data=%h id=%0d, required addr=%0d data=%h id=%0d",
                             rf_waddr, rf_wdata, grant_id, e.addr, e.data, e.id);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] id);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.id   = id;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        req_valid = '0;
        rf_stall  = 1'b0;
        rst_n     = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        rf_stall  = 1'b0;
        rst_n     = 1'b0;
        #3;
        checks++;
        if (rf_we !== 1'b0 || req_ready !== 4'b0000 || rf_waddr !== 3'd0 ||
            rf_wdata !== 16'h0000 || grant_id !== 2'd0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got we=%b rdy=%b addr=%0d data=%h id=%0d idle=%b, required 0 0000 0 0000 0 1",
                     rf_we, req_ready, rf_waddr, rf_wdata, grant_id, idle);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        // Load one write, then kill it with an asynchronous reset.
        set_req(0, 3'd2, 16'h5555);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        #1;
        checks++;
        if (rf_we !== 1'b1) begin
            errors++;
            $display("FAIL reset_prewrite_we: got %b, required 1", rf_we);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_we: got %b, required 0", rf_we);
        end
        #3;
        rst_n = 1'b1;
        tick();
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle: got %b, required 1", idle);
        end
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_rr_ptr: got ready=%b, required 0001", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_single();
        do_reset();
        set_req(0, 3'd3, 16'hBEEF);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_ready: got %b, required 0001", req_ready);
        end
        push(3'd3, 16'hBEEF, 2'd0);
        tick();
        req_valid = '0;
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 3'd3 || rf_wdata !== 16'hBEEF || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL single_out: got we=%b addr=%0d data=%h id=%0d, required 1 3 beef 0",
                     rf_we, rf_waddr, rf_wdata, grant_id);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int ptr;
        int order[5] = '{0, 1, 2, 3, 0};
        int wes;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 3'(i + 1), 16'(16'h1000 + i));
        req_valid = 4'b1111;
        ptr = 0;
        wes = 0;
        for (int c = 0; c < 5; c++) begin
            logic [3:0] exp_rdy;
            exp_rdy = 4'b0001 << order[c];
            #1;
            checks++;
            if (req_ready !== exp_rdy || ptr != order[c]) begin
                errors++;
                $display("FAIL rr_grant_%0d: got ready=%b, required %b", c, req_ready, exp_rdy);
            end
            push(3'(order[c] + 1), 16'(16'h1000 + order[c]), 2'(order[c]));
            tick();
            ptr = (ptr + 1) % NREQ;
            if (rf_we === 1'b1) wes++;
        end
        req_valid = '0;
        tick();
        checks++;
        if (wes != 5) begin
            errors++;
            $display("FAIL rr_throughput: got %0d write cycles, required 5", wes);
        end
    endtask

    task automatic test_stall();
        do_reset();
        set_req(1, 3'd5, 16'h00AA);
        req_valid = 4'b0010;
        rf_stall  = 1'b1;
        push(3'd5, 16'h00AA, 2'd1);
        tick();
        set_req(2, 3'd6, 16'h00BB);
        req_valid = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (rf_we !== 1'b0 || req_ready !== 4'b0000 || rf_waddr !== 3'd5 ||
                rf_wdata !== 16'h00AA || grant_id !== 2'd1) begin
                errors++;
                $display("FAIL stall_hold_%0d: got we=%b rdy=%b addr=%0d data=%h id=%0d, required 0 0000 5 00aa 1",
                         c, rf_we, req_ready, rf_waddr, rf_wdata, grant_id);
            end
            tick();
        end
        rf_stall = 1'b0;
        #1;
        checks++;
        if (rf_we !== 1'b1 || req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL stall_release: got we=%b rdy=%b, required 1 0100", rf_we, req_ready);
        end
        push(3'd6, 16'h00BB, 2'd2);
        tick();
        req_valid = '0;
        tick();
    endtask

    task automatic test_zero_reg();
        do_reset();
        set_req(3, 3'd0, 16'hFFFF);
        req_valid = 4'b1000;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL zero_ready: got %b, required 1000", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL zero_we: got %b, required 0", rf_we);
        end
        set_req(1, 3'd7, 16'h1234);
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL zero_next_ready: got %b, required 0010", req_ready);
        end
        push(3'd7, 16'h1234, 2'd1);
        tick();
        req_valid = '0;
        tick();
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL zero_idle: got %b, required 1", idle);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        // Grant requester 2 alone so the pointer lands on 3.
        set_req(2, 3'd4, 16'h2222);
        req_valid = 4'b0100;
        push(3'd4, 16'h2222, 2'd2);
        tick();
        set_req(0, 3'd1, 16'h0A0A);
        set_req(2, 3'd2, 16'h2B2B);
        req_valid = 4'b0101;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_grant0: got %b, required 0001", req_ready);
        end
        push(3'd1, 16'h0A0A, 2'd0);
        tick();
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL wrap_grant2: got %b, required 0100", req_ready);
        end
        push(3'd2, 16'h2B2B, 2'd2);
        tick();
        req_valid = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_zero_reg();
        test_wrap();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending writes, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
